// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns ASCII command bytes from a show-ahead RX FIFO into
// the PC-side control set (button pulses, set level, mode value, source select).
// Two-byte mode command '#<hex>' with an argument timeout; bad bytes pulse oErr.
module uart_cmd_decoder #(
  parameter int unsigned P_TIMEOUT_CYC = 100_000_000,
  parameter int unsigned P_MODE_MAX    = 9
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iRx_Data,
  input  logic       iRx_Empty,
  output logic       oRx_Pop,
  output logic       oMode_Sel,
  output logic       oPC_Set,
  output logic [3:0] oPC_Mode,
  output logic       oPC_Btn_U,
  output logic       oPC_Btn_D,
  output logic       oPC_Btn_L,
  output logic       oPC_Btn_R,
  output logic       oErr
);

  // A one-cycle timeout still needs a one-bit counter.
  localparam int unsigned LP_CNT_W = (P_TIMEOUT_CYC > 1) ? $clog2(P_TIMEOUT_CYC) : 1;
  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(P_TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StArgWait,
    StArgDecode
  } state_e;

  state_e              r_state;
  logic [7:0]          r_byte;
  logic [LP_CNT_W-1:0] r_cnt;

  logic       r_rx_pop;
  logic       r_mode_sel;
  logic       r_pc_set;
  logic [3:0] r_pc_mode;
  logic       r_btn_u;
  logic       r_btn_d;
  logic       r_btn_l;
  logic       r_btn_r;
  logic       r_err;

  logic       w_is_u;
  logic       w_is_d;
  logic       w_is_l;
  logic       w_is_r;
  logic       w_is_set;
  logic       w_is_sel;
  logic       w_is_hash;
  logic       w_is_bad;

  logic       w_arg_hex;
  logic [3:0] w_arg_val;
  logic       w_arg_ok;

  // Classify the latched byte as a command (case-insensitive letters).
  always_comb begin
    w_is_u    = 1'b0;
    w_is_d    = 1'b0;
    w_is_l    = 1'b0;
    w_is_r    = 1'b0;
    w_is_set  = 1'b0;
    w_is_sel  = 1'b0;
    w_is_hash = 1'b0;
    w_is_bad  = 1'b0;
    unique case (r_byte)
      8'h55, 8'h75: w_is_u    = 1'b1;  // U u
      8'h44, 8'h64: w_is_d    = 1'b1;  // D d
      8'h4C, 8'h6C: w_is_l    = 1'b1;  // L l
      8'h52, 8'h72: w_is_r    = 1'b1;  // R r
      8'h53, 8'h73: w_is_set  = 1'b1;  // S s
      8'h4D, 8'h6D: w_is_sel  = 1'b1;  // M m
      8'h23:        w_is_hash = 1'b1;  // #
      8'h0D, 8'h0A: ;                  // CR / LF are silently ignored
      default:      w_is_bad  = 1'b1;
    endcase
  end

  // Decode the latched byte as a hex digit and range-check it against P_MODE_MAX.
  always_comb begin
    w_arg_hex = 1'b1;
    w_arg_val = 4'd0;
    if (r_byte >= 8'h30 && r_byte <= 8'h39) begin
      w_arg_val = 4'(r_byte - 8'h30);
    end else if (r_byte >= 8'h41 && r_byte <= 8'h46) begin
      w_arg_val = 4'(r_byte - 8'h37);
    end else if (r_byte >= 8'h61 && r_byte <= 8'h66) begin
      w_arg_val = 4'(r_byte - 8'h57);
    end else begin
      w_arg_hex = 1'b0;
    end
    w_arg_ok = w_arg_hex && ({28'd0, w_arg_val} <= P_MODE_MAX);
  end

  // Control FSM; every output is a register, pulses default low each cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= StIdle;
      r_byte     <= 8'd0;
      r_cnt      <= '0;
      r_rx_pop   <= 1'b0;
      r_mode_sel <= 1'b0;
      r_pc_set   <= 1'b0;
      r_pc_mode  <= 4'd0;
      r_btn_u    <= 1'b0;
      r_btn_d    <= 1'b0;
      r_btn_l    <= 1'b0;
      r_btn_r    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_pop <= 1'b0;
      r_btn_u  <= 1'b0;
      r_btn_d  <= 1'b0;
      r_btn_l  <= 1'b0;
      r_btn_r  <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!iRx_Empty) begin
            r_rx_pop <= 1'b1;
            r_byte   <= iRx_Data;
            r_state  <= StDecode;
          end
        end
        StDecode: begin
          r_state <= StIdle;
          r_btn_u <= w_is_u;
          r_btn_d <= w_is_d;
          r_btn_l <= w_is_l;
          r_btn_r <= w_is_r;
          r_err   <= w_is_bad;
          if (w_is_set) r_pc_set <= ~r_pc_set;
          if (w_is_sel) r_mode_sel <= ~r_mode_sel;
          if (w_is_hash) begin
            r_cnt   <= '0;
            r_state <= StArgWait;
          end
        end
        StArgWait: begin
          // Saturating increment: the timeout compare fires before the top is reached.
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (!iRx_Empty) begin
            r_rx_pop <= 1'b1;
            r_byte   <= iRx_Data;
            r_state  <= StArgDecode;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end
        end
        StArgDecode: begin
          // A rejected argument is consumed here, never re-decoded as a command.
          if (w_arg_ok) begin
            r_pc_mode <= w_arg_val;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign oRx_Pop   = r_rx_pop;
  assign oMode_Sel = r_mode_sel;
  assign oPC_Set   = r_pc_set;
  assign oPC_Mode  = r_pc_mode;
  assign oPC_Btn_U = r_btn_u;
  assign oPC_Btn_D = r_btn_d;
  assign oPC_Btn_L = r_btn_l;
  assign oPC_Btn_R = r_btn_r;
  assign oErr      = r_err;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: a queue-based show-ahead FIFO feeds the DUT, and a
// command-level model predicts the ordered list of visible effects (pulses and
// level changes) that the monitor must observe.
module tb_uart_cmd_decoder;

  localparam int unsigned TB_TIMEOUT = 16;
  localparam int unsigned TB_MODE_MAX = 9;

  localparam int E_U = 1, E_D = 2, E_L = 3, E_R = 4, E_ERR = 5, E_SET = 6, E_SEL = 7,
                 E_MODE = 8;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [7:0] iRx_Data;
  logic       iRx_Empty;
  logic       oRx_Pop;
  logic       oMode_Sel;
  logic       oPC_Set;
  logic [3:0] oPC_Mode;
  logic       oPC_Btn_U;
  logic       oPC_Btn_D;
  logic       oPC_Btn_L;
  logic       oPC_Btn_R;
  logic       oErr;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] fifo[$];
  int         exp_q[$];
  logic       pop_pending = 1'b0;
  logic       mon_en = 1'b0;

  // Model state and the monitor's view of the previous cycle's levels.
  logic       m_set, m_sel;
  logic [3:0] m_mode;
  logic       p_set, p_sel;
  logic [3:0] p_mode;

  string cmd_s = "UuDdLlRrSsMm";
  string hex_s = "0123456789ABCDEFabcdef";

  uart_cmd_decoder #(
    .P_TIMEOUT_CYC(TB_TIMEOUT),
    .P_MODE_MAX   (TB_MODE_MAX)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iRx_Data (iRx_Data),
    .iRx_Empty(iRx_Empty),
    .oRx_Pop  (oRx_Pop),
    .oMode_Sel(oMode_Sel),
    .oPC_Set  (oPC_Set),
    .oPC_Mode (oPC_Mode),
    .oPC_Btn_U(oPC_Btn_U),
    .oPC_Btn_D(oPC_Btn_D),
    .oPC_Btn_L(oPC_Btn_L),
    .oPC_Btn_R(oPC_Btn_R),
    .oErr     (oErr)
  );

  always #5 iClk = ~iClk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    iRx_Empty = (fifo.size() == 0);
    iRx_Data  = iRx_Empty ? 8'($urandom) : fifo[0];
  endtask

  task automatic expect_evt(input int kind, input int val);
    exp_q.push_back(kind * 256 + val);
  endtask

  // Turn this cycle's visible activity into events and match them in order.
  task automatic observe();
    int obs[$];
    int e;
    if (oPC_Btn_U) obs.push_back(E_U * 256);
    if (oPC_Btn_D) obs.push_back(E_D * 256);
    if (oPC_Btn_L) obs.push_back(E_L * 256);
    if (oPC_Btn_R) obs.push_back(E_R * 256);
    if (oErr) obs.push_back(E_ERR * 256);
    if (oPC_Set !== p_set) obs.push_back(E_SET * 256 + int'(oPC_Set));
    if (oMode_Sel !== p_sel) obs.push_back(E_SEL * 256 + int'(oMode_Sel));
    if (oPC_Mode !== p_mode) obs.push_back(E_MODE * 256 + int'(oPC_Mode));
    foreach (obs[i]) begin
      if (exp_q.size() == 0) begin
        check_eq("evt_unexpected", obs[i], 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("evt_order", obs[i], e);
      end
    end
    p_set  = oPC_Set;
    p_sel  = oMode_Sel;
    p_mode = oPC_Mode;
  endtask

  // One clock: the FIFO honours last cycle's pop at the edge, outputs sampled #1 later.
  task automatic tick();
    logic prev_pop;
    @(posedge iClk);
    if (pop_pending && fifo.size() != 0) void'(fifo.pop_front());
    #1;
    prev_pop    = pop_pending;
    pop_pending = oRx_Pop;
    if (!iRst) begin
      if (oRx_Pop) begin
        check_eq("pop_nonempty", 32'(fifo.size() != 0), 1);
        check_eq("pop_gap", prev_pop, 0);
      end
      check_eq("btn_onehot",
               32'($countones({oPC_Btn_U, oPC_Btn_D, oPC_Btn_L, oPC_Btn_R}) <= 1), 1);
    end
    if (mon_en) observe();
    drive_fifo();
  endtask

  task automatic model_cmd(input logic [7:0] b);
    case (b)
      "U", "u": expect_evt(E_U, 0);
      "D", "d": expect_evt(E_D, 0);
      "L", "l": expect_evt(E_L, 0);
      "R", "r": expect_evt(E_R, 0);
      "S", "s": begin
        m_set = ~m_set;
        expect_evt(E_SET, int'(m_set));
      end
      "M", "m": begin
        m_sel = ~m_sel;
        expect_evt(E_SEL, int'(m_sel));
      end
      8'h0D, 8'h0A: ;
      default: expect_evt(E_ERR, 0);
    endcase
  endtask

  task automatic model_arg(input logic [7:0] b);
    int v;
    v = -1;
    if (b >= "0" && b <= "9") v = int'(b) - 48;
    else if (b >= "A" && b <= "F") v = int'(b) - 55;
    else if (b >= "a" && b <= "f") v = int'(b) - 87;
    if (v >= 0 && v <= int'(TB_MODE_MAX)) begin
      if (v != int'(m_mode)) expect_evt(E_MODE, v);
      m_mode = 4'(v);
    end else begin
      expect_evt(E_ERR, 0);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    model_cmd(b);
    fifo.push_back(b);
    drive_fifo();
  endtask

  task automatic send_mode(input logic [7:0] a);
    model_arg(a);
    fifo.push_back(8'h23);
    fifo.push_back(a);
    drive_fifo();
  endtask

  task automatic send_lone_hash();
    expect_evt(E_ERR, 0);
    fifo.push_back(8'h23);
    drive_fifo();
  endtask

  task automatic wait_drain(input int extra);
    int n;
    n = 0;
    while ((fifo.size() != 0 || pop_pending) && n < 500) begin
      tick();
      n++;
    end
    check_eq("drain_bound", 32'(n < 500), 1);
    repeat (extra) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pop"}, oRx_Pop, 0);
    check_eq({tag, "_sel"}, oMode_Sel, 0);
    check_eq({tag, "_set"}, oPC_Set, 0);
    check_eq({tag, "_mode"}, oPC_Mode, 0);
    check_eq({tag, "_btn"}, {oPC_Btn_U, oPC_Btn_D, oPC_Btn_L, oPC_Btn_R}, 0);
    check_eq({tag, "_err"}, oErr, 0);
  endtask

  task automatic clear_model();
    m_set = 1'b0; m_sel = 1'b0; m_mode = 4'd0;
    p_set = 1'b0; p_sel = 1'b0; p_mode = 4'd0;
  endtask

  initial begin
    int sel;
    logic [7:0] b;

    // Power-on reset
    iRst = 1'b1;
    drive_fifo();
    repeat (3) tick();
    check_reset_outputs("rst0");
    iRst = 1'b0;
    clear_model();
    mon_en = 1'b1;

    // Single 'U': pop next cycle, pulse two cycles after the byte appears
    send_cmd("U");
    tick();
    check_eq("u_pop", oRx_Pop, 1);
    check_eq("u_early", oPC_Btn_U, 0);
    tick();
    check_eq("u_pulse", oPC_Btn_U, 1);
    tick();
    check_eq("u_end", oPC_Btn_U, 0);
    check_eq("u_pop_end", oRx_Pop, 0);
    wait_drain(2);

    // Level toggles
    send_cmd("M"); send_cmd("S"); send_cmd("M");
    wait_drain(3);
    check_eq("msm_sel", oMode_Sel, 0);
    check_eq("msm_set", oPC_Set, 1);

    // Back-to-back buttons, spaced two cycles apart
    send_cmd("d"); send_cmd("l"); send_cmd("r");
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 2) check_eq("b2b_d", oPC_Btn_D, 1);
      if (t == 4) check_eq("b2b_l", oPC_Btn_L, 1);
      if (t == 6) check_eq("b2b_r", oPC_Btn_R, 1);
      if (t == 3 || t == 5)
        check_eq("b2b_gap", {oPC_Btn_U, oPC_Btn_D, oPC_Btn_L, oPC_Btn_R}, 0);
    end
    wait_drain(3);

    // Mode commands: load, out-of-range reject, reload
    send_mode("7");
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t == 3) begin
        check_eq("m7_pop2", oRx_Pop, 1);
        check_eq("m7_before", oPC_Mode, 0);
      end
      if (t == 4) check_eq("m7_load", oPC_Mode, 7);
    end
    wait_drain(3);
    send_mode("a");
    wait_drain(3);
    check_eq("ma_hold", oPC_Mode, 7);
    send_mode("5");
    wait_drain(3);
    check_eq("m5_load", oPC_Mode, 5);

    // Argument timeout: ARG_WAIT entered after tick 2, error after 16 more cycles
    send_lone_hash();
    for (int t = 1; t <= 19; t++) begin
      tick();
      if (t == 17) check_eq("to_early", oErr, 0);
      if (t == 18) check_eq("to_err", oErr, 1);
      if (t == 19) check_eq("to_end", oErr, 0);
    end
    send_cmd("U");
    wait_drain(3);

    // Bad byte plus ignored CR/LF
    send_cmd("x"); send_cmd(8'h0D); send_cmd(8'h0A);
    wait_drain(3);

    // Randomized command stream
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) begin
        if ($urandom_range(0, 3) != 0) begin
          sel = int'($urandom_range(0, 13));
          b = (sel == 12) ? 8'h0D : (sel == 13) ? 8'h0A : cmd_s[sel];
        end else begin
          b = 8'($urandom);
          if (b == 8'h23) b = 8'h3F;
        end
        send_cmd(b);
      end else if (sel <= 8) begin
        if ($urandom_range(0, 2) != 0) b = hex_s[$urandom_range(0, 21)];
        else b = 8'($urandom);
        send_mode(b);
      end else begin
        wait_drain(3);
        send_lone_hash();
        wait_drain(24);
      end
      if ($urandom_range(0, 3) == 0) wait_drain(3);
    end
    wait_drain(4);
    check_eq("rand_drained", exp_q.size(), 0);

    // Reset while waiting for an argument
    fifo.push_back(8'h23);
    drive_fifo();
    repeat (3) tick();
    check_eq("pre_rst_q", exp_q.size(), 0);
    mon_en = 1'b0;
    iRst = 1'b1;
    tick();
    check_reset_outputs("rst1");
    iRst = 1'b0;
    clear_model();
    mon_en = 1'b1;
    send_cmd("3");
    wait_drain(3);
    check_eq("post_rst_mode", oPC_Mode, 0);
    check_eq("final_q", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
